action_sequencer: RTL

Input-side front end for the fighting game core. It turns raw per-player buttons into the 3-bit action codes and the single-cycle `actionEnable` strobe that the game core consumes. It synchronises and debounces each button, priority-encodes one action per player per round, collects both players' choices (or times out), and fires one round strobe with both codes stable.

---
 rtl/fight_pkg.sv | 24 ++
 rtl/button_debouncer.sv | 43 ++++
 rtl/action_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/fight_pkg.sv
// Shared action codes, button bit positions and sequencer state encoding for the
// fighting-game input front end.
package fight_pkg;

    localparam int ACT_W = 3;

    localparam logic [ACT_W-1:0] ACT_NONE   = 3'b000;
    localparam logic [ACT_W-1:0] ACT_LEFT   = 3'b001;
    localparam logic [ACT_W-1:0] ACT_RIGHT  = 3'b010;
    localparam logic [ACT_W-1:0] ACT_ATTACK = 3'b011;
    localparam logic [ACT_W-1:0] ACT_DEFEND = 3'b100;

    localparam int BTN_LEFT   = 0;
    localparam int BTN_RIGHT  = 1;
    localparam int BTN_ATTACK = 2;
    localparam int BTN_DEFEND = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_FIRE    = 2'd2
    } seq_state_t;

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-flop synchroniser, stability counter, debounced level and a
// registered one-cycle pulse on each debounced rising edge.
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic resetGame,
    input  logic btn,
    output logic rise
);

    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic          sync_p0;
    logic          sync_p1;
    logic          level;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (resetGame) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            level   <= 1'b0;
            cnt     <= '0;
            rise    <= 1'b0;
        end else begin
            sync_p0 <= btn;
            sync_p1 <= sync_p0;
            rise    <= 1'b0;
            // The level flips on the DEBOUNCE_CYCLES-th consecutive disagreeing sample.
            if (sync_p1 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                level <= sync_p1;
                cnt   <= '0;
                rise  <= sync_p1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/action_sequencer.sv
// Debounces both players' buttons, latches one action per player per round and
// fires a single actionEnable strobe. Round timeout is enabled by ACTION_SEQ_TIMEOUT_EN.
module action_sequencer
    import fight_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int ROUND_CYCLES    = 16
) (
    input  logic             clk,
    input  logic             resetGame,
    input  logic [3:0]       btn1,
    input  logic [3:0]       btn2,
    input  logic             gameOver,
    output logic [ACT_W-1:0] action1,
    output logic [ACT_W-1:0] action2,
    output logic             actionEnable,
    output logic             pending1,
    output logic             pending2
);

    logic [3:0]       rise1;
    logic [3:0]       rise2;
    logic [ACT_W-1:0] code1;
    logic [ACT_W-1:0] code2;
    logic [ACT_W-1:0] slot1;
    logic [ACT_W-1:0] slot2;
    logic             cap1;
    logic             cap2;
    logic             timeout;
    seq_state_t       state;
    seq_state_t       state_nx;

    function automatic logic [ACT_W-1:0] encode_press(input logic [3:0] r);
        logic [ACT_W-1:0] code;
        code = ACT_NONE;
        if (r[BTN_ATTACK])      code = ACT_ATTACK;
        else if (r[BTN_DEFEND]) code = ACT_DEFEND;
        else if (r[BTN_LEFT])   code = ACT_LEFT;
        else if (r[BTN_RIGHT])  code = ACT_RIGHT;
        return code;
    endfunction

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db1 (
            .clk       (clk),
            .resetGame (resetGame),
            .btn       (btn1[i]),
            .rise      (rise1[i])
        );
        button_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db2 (
            .clk       (clk),
            .resetGame (resetGame),
            .btn       (btn2[i]),
            .rise      (rise2[i])
        );
    end

    always_comb begin
        code1 = encode_press(rise1);
        code2 = encode_press(rise2);
        // A slot being cleared by FIRE counts as empty so a same-cycle press survives.
        cap1  = !gameOver && (code1 != ACT_NONE) && (!pending1 || state == ST_FIRE);
        cap2  = !gameOver && (code2 != ACT_NONE) && (!pending2 || state == ST_FIRE);

        state_nx = state;
        case (state)
            ST_IDLE:    if (cap1 || cap2) state_nx = ST_COLLECT;
            ST_COLLECT: if ((pending1 && pending2) || timeout) state_nx = ST_FIRE;
            ST_FIRE:    state_nx = (cap1 || cap2) ? ST_COLLECT : ST_IDLE;
            default:    state_nx = ST_IDLE;
        endcase
        if (gameOver) state_nx = ST_IDLE;
    end

`ifdef ACTION_SEQ_TIMEOUT_EN
    localparam int TW = $clog2(ROUND_CYCLES);

    logic [TW-1:0] timer;

    always_ff @(posedge clk) begin
        if (resetGame || state != ST_COLLECT || state_nx != ST_COLLECT) begin
            timer <= '0;
        end else begin
            timer <= timer + 1'b1;
        end
    end

    assign timeout = (state == ST_COLLECT) && (timer == TW'(ROUND_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (resetGame || gameOver) begin
            slot1    <= ACT_NONE;
            pending1 <= 1'b0;
        end else if (cap1) begin
            slot1    <= code1;
            pending1 <= 1'b1;
        end else if (state == ST_FIRE) begin
            slot1    <= ACT_NONE;
            pending1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (resetGame || gameOver) begin
            slot2    <= ACT_NONE;
            pending2 <= 1'b0;
        end else if (cap2) begin
            slot2    <= code2;
            pending2 <= 1'b1;
        end else if (state == ST_FIRE) begin
            slot2    <= ACT_NONE;
            pending2 <= 1'b0;
        end
    end

    // Outputs are registered on entry to FIRE so codes and strobe appear together.
    always_ff @(posedge clk) begin
        if (resetGame) begin
            state        <= ST_IDLE;
            actionEnable <= 1'b0;
            action1      <= ACT_NONE;
            action2      <= ACT_NONE;
        end else begin
            state        <= state_nx;
            actionEnable <= (state_nx == ST_FIRE);
            if (state_nx == ST_FIRE) begin
                action1 <= slot1;
                action2 <= slot2;
            end
        end
    end

endmodule
